// File: rtl/data_ram_responder.sv
// Data-memory responder: word RAM behind a waitrequest handshake with fixed
// wait-state latency; reports misaligned, out-of-range and read+write requests.
// Ports:
//   clk, reset (sync, active-high)
//   address, read, write, writedata, byteenable  (master request)
//   readdata, waitrequest, err                   (response)
// Params: DEPTH_WORDS, LATENCY (1..15), BASE_ADDR.
// Build option: define DATA_RAM_BYTE_ENABLE_EN to honour byteenable on writes;
// otherwise every successful write updates the full word.
module data_ram_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          rd_q;
  logic          wr_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          bad;
  logic          req;
  logic [3:0]    lanes;

`ifdef DATA_RAM_BYTE_ENABLE_EN
  logic [3:0] be_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      be_q <= '0;
    end else if (state == IDLE && req) begin
      be_q <= byteenable;
    end
  end

  assign lanes = be_q;
`else
  logic be_unused;

  assign be_unused = ^byteenable;
  assign lanes     = 4'hF;
`endif

  assign req = read | write;

  // Offset wraps for addresses below the base; the explicit
  // compare catches those before the range check sees a huge idx.
  assign off = addr_q - BASE_ADDR;
  assign idx = off[AW+1:2];

  assign bad = (addr_q[1:0] != 2'b00)
             || (addr_q < BASE_ADDR)
             || ((off >> 2) >= 32'(DEPTH_WORDS))
             || (rd_q && wr_q);

  always_comb begin
    waitrequest = 1'b0;
    unique case (state)
      IDLE:    waitrequest = req;
      BUSY:    waitrequest = 1'b1;
      default: waitrequest = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      readdata <= '0;
      err      <= 1'b0;
    end else begin
      readdata <= '0;
      err      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= address;
            wdata_q <= writedata;
            rd_q    <= read;
            wr_q    <= write;
            cnt     <= CNT_INIT;
            state   <= BUSY;
          end
        end
        BUSY: begin
          // Master withdrew the request: abandon quietly.
          if (!req) begin
            state <= IDLE;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= DONE;
            err   <= bad;
            if (rd_q && !bad) begin
              readdata <= mem[idx];
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Commit happens on the edge that ends DONE.
  always_ff @(posedge clk) begin
    if (!reset && state == DONE && wr_q && !bad) begin
      for (int i = 0; i < 4; i++) begin
        if (lanes[i]) begin
          mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule
